// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: owns the single write port of the integer register file.
// Writeback writes always win. One debug write can be buffered and is
// issued in the next free slot. Optional starvation guard (compile with
// RF_WR_ARB_STARVE_EN): after STARVE_LIMIT-1 blocked cycles the arbiter
// raises hold_o until the debug write gets its slot.
//
// Handshake: a debug request transfers on a rising edge where
// dbg_valid_i && dbg_ready_o. dbg_ready_o is high only while IDLE, so at
// most one debug write is outstanding. dbg_done_o pulses for one cycle,
// together with the registered write (or with no write, for dst 0).
module rf_wr_arbiter #(
  parameter int XLEN         = 32,
  parameter int AR_BITS      = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_we_i,
  input  logic [AR_BITS-1:0] wb_dst_i,
  input  logic [XLEN-1:0]    wb_r_i,
  input  logic               dbg_valid_i,
  output logic               dbg_ready_o,
  input  logic [AR_BITS-1:0] dbg_dst_i,
  input  logic [XLEN-1:0]    dbg_data_i,
  output logic               dbg_done_o,
  output logic               hold_o,
  output logic               rf_we_o,
  output logic [AR_BITS-1:0] rf_dst_o,
  output logic [XLEN-1:0]    rf_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A starvation threshold below 2 cannot be met by the counter.
  if (STARVE_LIMIT < 2) begin : g_bad_limit
    $error("rf_wr_arbiter: STARVE_LIMIT must be >= 2");
  end

  state_t               state_q, state_d;
  logic [AR_BITS-1:0]   pend_dst_q, pend_dst_d;
  logic [XLEN-1:0]      pend_data_q, pend_data_d;
  logic                 rf_we_q, rf_we_d;
  logic [AR_BITS-1:0]   rf_dst_q, rf_dst_d;
  logic [XLEN-1:0]      rf_data_q, rf_data_d;
  logic                 done_q, done_d;
  logic                 slot_busy;

`ifdef RF_WR_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  // Counter value one step before reaching STARVE_LIMIT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 2);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hold_q, hold_d;
`endif

  // A WB write to x0 is dropped and leaves the slot free for debug.
  assign slot_busy = wb_we_i && (wb_dst_i != '0);

  // Next-state, pending buffer and registered port decision.
  always_comb begin
    state_d     = state_q;
    pend_dst_d  = pend_dst_q;
    pend_data_d = pend_data_q;
    rf_we_d     = 1'b0;
    rf_dst_d    = '0;
    rf_data_d   = '0;
    done_d      = 1'b0;
`ifdef RF_WR_ARB_STARVE_EN
    cnt_d       = cnt_q;
`endif
    if (slot_busy) begin
      rf_we_d   = 1'b1;
      rf_dst_d  = wb_dst_i;
      rf_data_d = wb_r_i;
    end
    case (state_q)
      IDLE: begin
        // Capture only; issue is never earlier than the cycle after.
        if (dbg_valid_i) begin
          state_d     = PEND;
          pend_dst_d  = dbg_dst_i;
          pend_data_d = dbg_data_i;
`ifdef RF_WR_ARB_STARVE_EN
          cnt_d       = '0;
`endif
        end
      end
      PEND, HOLD: begin
        if (!slot_busy) begin
          // Debug write to x0 completes without touching the port.
          rf_we_d   = (pend_dst_q != '0);
          rf_dst_d  = (pend_dst_q != '0) ? pend_dst_q : '0;
          rf_data_d = (pend_dst_q != '0) ? pend_data_q : '0;
          done_d    = 1'b1;
          state_d   = IDLE;
`ifdef RF_WR_ARB_STARVE_EN
          cnt_d     = '0;
`endif
        end
`ifdef RF_WR_ARB_STARVE_EN
        else if (state_q == PEND) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RF_WR_ARB_STARVE_EN
  // hold_o is high exactly while the FSM sits in HOLD.
  always_comb begin
    hold_d = (state_d == HOLD);
  end
`endif

  // State and output registers; reset discards any pending debug write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_dst_q  <= '0;
      pend_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_dst_q    <= '0;
      rf_data_q   <= '0;
      done_q      <= 1'b0;
`ifdef RF_WR_ARB_STARVE_EN
      cnt_q       <= '0;
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_dst_q  <= pend_dst_d;
      pend_data_q <= pend_data_d;
      rf_we_q     <= rf_we_d;
      rf_dst_q    <= rf_dst_d;
      rf_data_q   <= rf_data_d;
      done_q      <= done_d;
`ifdef RF_WR_ARB_STARVE_EN
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
`endif
    end
  end

  assign dbg_ready_o = (state_q == IDLE);
  assign dbg_done_o  = done_q;
  assign rf_we_o     = rf_we_q;
  assign rf_dst_o    = rf_dst_q;
  assign rf_data_o   = rf_data_q;
`ifdef RF_WR_ARB_STARVE_EN
  assign hold_o      = hold_q;
`else
  assign hold_o      = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed vectors for rf_wr_arbiter with hand-computed
// expectations. Build with RF_WR_ARB_STARVE_EN to exercise the hold path.
module tb_rf_wr_arbiter;

  localparam int XLEN    = 32;
  localparam int AR_BITS = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               wb_we_i = 1'b0;
  logic [AR_BITS-1:0] wb_dst_i = '0;
  logic [XLEN-1:0]    wb_r_i = '0;
  logic               dbg_valid_i = 1'b0;
  logic               dbg_ready_o;
  logic [AR_BITS-1:0] dbg_dst_i = '0;
  logic [XLEN-1:0]    dbg_data_i = '0;
  logic               dbg_done_o;
  logic               hold_o;
  logic               rf_we_o;
  logic [AR_BITS-1:0] rf_dst_o;
  logic [XLEN-1:0]    rf_data_o;

  rf_wr_arbiter #(.XLEN(XLEN), .AR_BITS(AR_BITS), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i), .wb_r_i(wb_r_i),
    .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o),
    .dbg_dst_i(dbg_dst_i), .dbg_data_i(dbg_data_i),
    .dbg_done_o(dbg_done_o), .hold_o(hold_o),
    .rf_we_o(rf_we_o), .rf_dst_o(rf_dst_o), .rf_data_o(rf_data_o)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] rf_model [32];

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register-file image, plus the port invariant checked on every write.
  always @(negedge clk) begin
    if (rst_n && rf_we_o) begin
      check("rf_dst_nonzero", {31'd0, rf_dst_o != '0}, 32'd1);
      rf_model[rf_dst_o] = rf_data_o;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we,
                            input logic [AR_BITS-1:0] dst,
                            input logic [XLEN-1:0] data);
    check({tag, "_we"}, {31'd0, rf_we_o}, {31'd0, we});
    if (we) begin
      check({tag, "_dst"}, {27'd0, rf_dst_o}, {27'd0, dst});
      check({tag, "_data"}, rf_data_o, data);
    end
  endtask

  task automatic check_ctl(input string tag, input logic rdy,
                           input logic done, input logic hold);
    check({tag, "_ready"}, {31'd0, dbg_ready_o}, {31'd0, rdy});
    check({tag, "_done"}, {31'd0, dbg_done_o}, {31'd0, done});
    check({tag, "_hold"}, {31'd0, hold_o}, {31'd0, hold});
  endtask

  task automatic wb_drive(input logic we, input logic [AR_BITS-1:0] dst,
                          input logic [XLEN-1:0] data);
    wb_we_i  = we;
    wb_dst_i = dst;
    wb_r_i   = data;
  endtask

  task automatic dbg_drive(input logic v, input logic [AR_BITS-1:0] dst,
                           input logic [XLEN-1:0] data);
    dbg_valid_i = v;
    dbg_dst_i   = dst;
    dbg_data_i  = data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    // reset state
    #2;
    check_port("rst", 1'b0, '0, '0);
    check({"rst", "_dst"}, {27'd0, rf_dst_o}, 32'd0);
    check({"rst", "_data"}, rf_data_o, 32'd0);
    check_ctl("rst", 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // WB only
    wb_drive(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_port("wb5", 1'b1, 5'd5, 32'hDEADBEEF);
    wb_drive(1'b0, '0, '0);
    tick();
    check_port("wb_idle", 1'b0, '0, '0);

    // debug write into an idle pipe: write two cycles after handshake
    check_ctl("dbg7_pre", 1'b1, 1'b0, 1'b0);
    dbg_drive(1'b1, 5'd7, 32'h1234);
    tick();
    dbg_drive(1'b0, '0, '0);
    check_port("dbg7_cap", 1'b0, '0, '0);
    check_ctl("dbg7_cap", 1'b0, 1'b0, 1'b0);
    tick();
    check_port("dbg7_iss", 1'b1, 5'd7, 32'h1234);
    check_ctl("dbg7_iss", 1'b1, 1'b1, 1'b0);
    tick();
    check_port("dbg7_after", 1'b0, '0, '0);
    check_ctl("dbg7_after", 1'b1, 1'b0, 1'b0);
    check("rf7", rf_model[7], 32'h1234);

    // starvation: WB busy every cycle while debug write to 9 waits
    wb_drive(1'b1, 5'd3, 32'h33);
    dbg_drive(1'b1, 5'd9, 32'h9999);
    tick();
    dbg_drive(1'b0, '0, '0);
    check_port("st_cap", 1'b1, 5'd3, 32'h33);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_port("st_wb", 1'b1, 5'd3, 32'h33);
`ifdef RF_WR_ARB_STARVE_EN
      // hold_o rises at the 7th blocked cycle and stays up
      check_ctl("st_blk", 1'b0, 1'b0, (c >= 7) ? 1'b1 : 1'b0);
`else
      check_ctl("st_blk", 1'b0, 1'b0, 1'b0);
`endif
    end
    wb_drive(1'b0, '0, '0);
    tick();
    check_port("st_iss", 1'b1, 5'd9, 32'h9999);
    check_ctl("st_iss", 1'b1, 1'b1, 1'b0);
    tick();
    check_ctl("st_after", 1'b1, 1'b0, 1'b0);

    // same-dst collision: WB 0x55 then debug 0xAA to reg 4
    dbg_drive(1'b1, 5'd4, 32'hAA);
    tick();
    dbg_drive(1'b0, '0, '0);
    wb_drive(1'b1, 5'd4, 32'h55);
    tick();
    wb_drive(1'b0, '0, '0);
    check_port("col_wb", 1'b1, 5'd4, 32'h55);
    check_ctl("col_wb", 1'b0, 1'b0, 1'b0);
    tick();
    check_port("col_dbg", 1'b1, 5'd4, 32'hAA);
    check_ctl("col_dbg", 1'b1, 1'b1, 1'b0);
    tick();
    check("rf4_final", rf_model[4], 32'hAA);

    // zero destination from both sources: done pulses, no port write
    wb_drive(1'b1, 5'd0, 32'hFFFF);
    dbg_drive(1'b1, 5'd0, 32'h77);
    tick();
    dbg_drive(1'b0, '0, '0);
    check_port("zero_cap", 1'b0, '0, '0);
    tick();
    check_port("zero_iss", 1'b0, '0, '0);
    check_ctl("zero_iss", 1'b1, 1'b1, 1'b0);
    wb_drive(1'b0, '0, '0);
    tick();
    check_port("zero_after", 1'b0, '0, '0);
    check_ctl("zero_after", 1'b1, 1'b0, 1'b0);

    // reset mid-PEND: write to 2 blocked by WB, then reset
    wb_drive(1'b1, 5'd6, 32'h66);
    dbg_drive(1'b1, 5'd2, 32'h22);
    tick();
    dbg_drive(1'b0, '0, '0);
    tick();
    check_ctl("rp_pend", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_port("rp_rst", 1'b0, '0, '0);
    check_ctl("rp_rst", 1'b1, 1'b0, 1'b0);
    wb_drive(1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_port("rp_post", 1'b0, '0, '0);
      check_ctl("rp_post", 1'b1, 1'b0, 1'b0);
    end
    check("rf2_untouched", rf_model[2], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
